hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Sequencer for the HI/LO unit behind the decoder's DIV, DIVU, MFHI and MFLO classes, with MTHI and MTLO added.
- Owns the HI and LO registers and runs a 32-iteration restoring divider.
- Stalls the pipeline when an HI/LO-class op arrives while a divide is in flight.
- Sits beside the ALU in the execute stage and is fed by decode control plus register-file read values.

Parameters:
- XLEN, 32, operand and HI/LO width. The iteration count equals XLEN.
- CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  an HI/LO-class op is present this cycle
- op_code  in  3  0=DIV 1=DIVU 2=MFHI 3=MFLO 4=MTHI 5=MTLO; 6 and 7 are ignored
- rs_val  in  XLEN  dividend / MTHI / MTLO source
- rt_val  in  XLEN  divisor
- kill  in  1  squash the in-flight divide (exception or flush)
- stall  out  1  pipeline must hold op_valid/op_code/operands
- busy  out  1  divider occupied
- result  out  XLEN  MFHI/MFLO read data, valid when op accepted
- hi  out  XLEN  current HI register
- lo  out  XLEN  current LO register

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, hi=0, lo=0, busy=0, stall=0, counter=0. Reset mid-divide discards all work.
- Accept rule: an op is accepted in a cycle with op_valid=1 and stall=0.
  - stall = op_valid & busy, combinational. While stalled, the op is not consumed.
- States:
  - IDLE: accepting DIV/DIVU latches the operands and goes to DIVIDE.
  - DIVIDE: 32 cycles, one quotient bit per cycle.
  - FIXUP: 1 cycle, then back to IDLE.
- busy=1 in DIVIDE and FIXUP, so 33 cycles starting the cycle after accept.
- New hi/lo are written at the edge that ends FIXUP. They are visible in the first cycle busy=0.
- DIV (signed) on accept: latch |rs_val| and |rt_val| as unsigned, plus sign_q = rs^rt sign bits and sign_r = rs sign bit.
- DIVU: latch raw values; signs forced to 0.
- DIVIDE iteration:
  - partial remainder {rem, quo} shifts left 1.
  - If rem ≥ divisor, subtract and set the quotient LSB.
  - Arithmetic runs at XLEN+1 bits to hold the carry.
- FIXUP:
  - lo = sign_q ? -quo : quo
  - hi = sign_r ? -rem : rem
- Divide by zero (rt_val=0): runs the full latency, sign fix is bypassed, lo = all ones, hi = original rs_val.
- Overflow, 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0. This falls out of unsigned magnitude plus negation and needs no special case.
- MFHI/MFLO:
  - result = hi or lo combinationally in the accept cycle.
  - result is 0 when no MF* op is accepted.
- MTHI/MTLO: write hi/lo at the accept edge. An MF* op in the next cycle sees the new value.
- kill:
  - In DIVIDE or FIXUP, the next state is IDLE. hi/lo are unchanged and busy=0 the next cycle.
  - In IDLE, an op presented the same cycle is dropped: no state change and no hi/lo write.
  - kill has priority over every other event.
- DIV/DIVU presented while busy stalls. It is then accepted in the first cycle busy=0, so back-to-back divides are spaced 34 cycles apart.
- op_code 6/7 with op_valid: ignored, no stall, no state change.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: in IDLE, if the unsigned magnitude of the divisor is greater than that of the dividend and the divisor is nonzero, skip DIVIDE and go straight to FIXUP with quo=0 and rem=|dividend|. busy lasts 1 cycle.
- When undefined: always the full 33-cycle busy period.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package hilo_pkg holds:
  - the op_code localparams (DIV..MTLO)
  - the state encoding (IDLE, DIVIDE, FIXUP)
  - the XLEN default
- One sub-module, div_iter: a combinational single restoring step taking {rem, quo, divisor} and returning {rem', quo'}, instantiated once.
- The FSM, counter, sign handling and HI/LO registers stay in hilo_div_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with op_valid=1 → hi=0, lo=0, busy=0, stall=0. Release, then MFHI → result=0.
- DIVU 100/7, then MFLO next cycle → stall=1 for 33 cycles; then result=14. Next-cycle MFHI → result=2.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5 after 33 busy cycles. DIV 0xFFFFFFFB/0 → lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- MTHI 0x11, then DIVU 9/3 with kill asserted on the 10th DIVIDE cycle → busy=0 next cycle, hi=0x11, lo unchanged. MFHI → 0x11.
- DIVU 3/10 → with DIV_EARLY_OUT_EN, busy=1 for 1 cycle; without it, 33 cycles. Both give lo=0, hi=3.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op codes, FSM encoding and width default for the HI/LO unit
package hilo_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_DIV  = 3'd0;
  localparam logic [2:0] OP_DIVU = 3'd1;
  localparam logic [2:0] OP_MFHI = 3'd2;
  localparam logic [2:0] OP_MFLO = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIXUP  = 2'd2
  } state_t;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - one combinational restoring-division step on {rem, quo}
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // Shift the partial remainder left, then subtract when it covers the divisor.
  // The low XLEN bits of the difference are exact because the result is below the divisor.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted[XLEN-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff;
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - HI/LO sequencer with restoring divider; DIV_EARLY_OUT_EN skips DIVIDE when |divisor| > |dividend|
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   divisor;
  logic              sign_q;
  logic              sign_r;
  logic              div_zero;

  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;
  logic              is_div;
  logic              is_known;
  logic              accept;
  logic              early_out;
  logic [XLEN-1:0]   mag_rs;
  logic [XLEN-1:0]   mag_rt;

  div_iter #(.XLEN(XLEN)) u_iter (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign busy     = (state != ST_IDLE);
  assign is_known = (op_code <= OP_MTLO);
  assign stall    = op_valid & busy & is_known;
  assign accept   = op_valid & ~stall & ~kill & ~busy;
  assign is_div   = (op_code == OP_DIV);
  assign mag_rs   = (is_div && rs_val[XLEN-1]) ? (~rs_val + 1'b1) : rs_val;
  assign mag_rt   = (is_div && rt_val[XLEN-1]) ? (~rt_val + 1'b1) : rt_val;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (mag_rt > mag_rs) && (rt_val != '0);
`else
  assign early_out = 1'b0;
`endif

  // MF* read data is only driven in the cycle the op is actually taken.
  always_comb begin
    result = '0;
    if (accept && op_code == OP_MFHI) result = hi;
    else if (accept && op_code == OP_MFLO) result = lo;
  end

  // Sequencer: kill wins, then idle-time ops, then the divide iterations and sign fixup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (kill) begin
      if (state != ST_IDLE) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op_code)
              OP_DIV, OP_DIVU: begin
                divisor  <= mag_rt;
                sign_q   <= is_div & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                sign_r   <= is_div & rs_val[XLEN-1];
                div_zero <= (rt_val == '0);
                cnt      <= '0;
                if (early_out) begin
                  rem   <= mag_rs;
                  quo   <= '0;
                  state <= ST_FIXUP;
                end else begin
                  rem   <= '0;
                  quo   <= mag_rs;
                  state <= ST_DIVIDE;
                end
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_DIVIDE: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == CNT_W'(XLEN - 1)) begin
            cnt   <= '0;
            state <= ST_FIXUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIXUP: begin
          // On a zero divisor the quotient is already all ones and rem holds |rs|;
          // re-applying the dividend sign to rem restores the original rs value.
          lo    <= (sign_q && !div_zero) ? (~quo + 1'b1) : quo;
          hi    <= sign_r ? (~rem + 1'b1) : rem;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb/tb_hilo_div_ctrl.sv - directed self-checking bench for hilo_div_ctrl
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        kill;
  logic        stall;
  logic        busy;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  int n;

`ifdef DIV_EARLY_OUT_EN
  localparam int EXP_EARLY_BUSY = 1;
`else
  localparam int EXP_EARLY_BUSY = 33;
`endif

  always #5 clk = ~clk;

  hilo_div_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .kill     (kill),
    .stall    (stall),
    .busy     (busy),
    .result   (result),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide, optionally probe an ignored op code in the first busy cycle,
  // and return the number of cycles busy stays high (bounded).
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit probe, output int cycles);
    op_valid = 1'b1;
    op_code  = op;
    rs_val   = a;
    rt_val   = b;
    step();
    op_valid = 1'b0;
    if (probe) begin
      op_valid = 1'b1;
      op_code  = 3'd7;
      #1;
      check("op7_no_stall", {31'b0, stall}, 32'd0);
      op_valid = 1'b0;
    end
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  task automatic mf(input string tag, input logic [2:0] op, input logic [31:0] exp);
    op_valid = 1'b1;
    op_code  = op;
    #1;
    check(tag, result, exp);
    step();
    op_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    op_valid = 1'b1;
    op_code  = 3'd4;
    rs_val   = 32'hDEAD_BEEF;
    rt_val   = 32'd0;
    kill     = 1'b0;
    step();
    step();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    mf("rst_mfhi", 3'd2, 32'd0);

    // DIVU 100/7 with MFLO waiting behind it
    op_valid = 1'b1;
    op_code  = 3'd1;
    rs_val   = 32'd100;
    rt_val   = 32'd7;
    step();
    op_code  = 3'd3;
    n = 0;
    while (stall && n < 100) begin
      n++;
      step();
    end
    check("divu_stall_cycles", n, 32'd33);
    check("divu_mflo", result, 32'd14);
    step();
    op_code = 3'd2;
    #1;
    check("divu_mfhi", result, 32'd2);
    step();
    op_valid = 1'b0;
    #1;
    check("idle_result_zero", result, 32'd0);

    run_div(3'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
    check("div_neg_busy", n, 32'd33);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_div(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    run_div(3'd1, 32'd5, 32'd0, 1'b1, n);
    check("divu_dz_busy", n, 32'd33);
    check("divu_dz_lo", lo, 32'hFFFF_FFFF);
    check("divu_dz_hi", hi, 32'd5);

    run_div(3'd0, 32'hFFFF_FFFB, 32'd0, 1'b0, n);
    check("div_dz_lo", lo, 32'hFFFF_FFFF);
    check("div_dz_hi", hi, 32'hFFFF_FFFB);

    // MTHI then a divide killed on its 10th DIVIDE cycle
    op_valid = 1'b1;
    op_code  = 3'd4;
    rs_val   = 32'h11;
    #1;
    check("mthi_result_zero", result, 32'd0);
    step();
    op_valid = 1'b0;
    check("mthi_hi", hi, 32'h11);
    op_valid = 1'b1;
    op_code  = 3'd1;
    rs_val   = 32'd9;
    rt_val   = 32'd3;
    step();
    op_valid = 1'b0;
    repeat (9) step();
    check("kill_pre_busy", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_hi", hi, 32'h11);
    check("kill_lo", lo, 32'hFFFF_FFFF);
    mf("kill_mfhi", 3'd2, 32'h11);

    // kill in IDLE drops a same-cycle MTLO
    kill     = 1'b1;
    op_valid = 1'b1;
    op_code  = 3'd5;
    rs_val   = 32'h55;
    step();
    kill     = 1'b0;
    op_valid = 1'b0;
    check("kill_idle_lo", lo, 32'hFFFF_FFFF);
    check("kill_idle_busy", {31'b0, busy}, 32'd0);

    // MTLO followed immediately by MFLO
    op_valid = 1'b1;
    op_code  = 3'd5;
    rs_val   = 32'hABCD;
    step();
    mf("mtlo_mflo", 3'd3, 32'hABCD);

    run_div(3'd1, 32'd3, 32'd10, 1'b0, n);
    check("early_busy", n, EXP_EARLY_BUSY);
    check("early_lo", lo, 32'd0);
    check("early_hi", hi, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
